// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding and the
// round-robin search helper used by rr_arbiter.
package uart_pkg;

  localparam int unsigned RR_MAX_REQ = 16;
  localparam int unsigned RR_IDX_W   = 4;

  typedef enum logic [2:0] {
    ARB       = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    GAP       = 3'd5
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  // First set bit of req searching ptr+1, ptr+2, ... modulo num_req.
  function automatic rr_result_t rr_next(input logic [RR_IDX_W-1:0]   ptr,
                                         input logic [RR_MAX_REQ-1:0] req,
                                         input int unsigned           num_req);
    rr_result_t          res;
    logic [RR_IDX_W-1:0] cand;
    res = '0;
    for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
      cand = RR_IDX_W'((32'(ptr) + i) % num_req);
      if ((i <= num_req) && !res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin priority search: one-hot grant and index of the
// first requester after ptr, wrapping around.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  rr_result_t res_s;

  // Priority search and one-hot decode of the winner.
  always_comb begin
    res_s = rr_next(RR_IDX_W'(ptr), RR_MAX_REQ'(req), NUM_REQ);
    found = res_s.found;
    idx   = IDX_W'(res_s.idx);
    if (res_s.found) begin
      grant = NUM_REQ'(1'b1) << idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART TX serializer between
// NUM_REQ byte-stream requesters, with an optional idle gap between packets.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_BITS  = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic [NUM_REQ*DATA_BITS-1:0]   i_data,
  input  logic [NUM_REQ-1:0]             i_valid,
  input  logic [NUM_REQ-1:0]             i_last,
  output logic [NUM_REQ-1:0]             o_ready,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic [DATA_BITS-1:0]           o_tx_data,
  output logic                           o_tx_start,
  input  logic                           i_tx_busy,
  output logic                           o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ - 1);

  arb_state_t           state_r, state_nxt_s;
  logic [NUM_REQ-1:0]   grant_r, grant_nxt_s, ready_s, arb_grant_s;
  logic [IDX_W-1:0]     gidx_r, gidx_nxt_s, ptr_r, ptr_nxt_s, arb_idx_s;
  logic                 arb_found_s, last_r, last_nxt_s, start_r, busy_r;
  logic [DATA_BITS-1:0] tx_data_r, tx_data_nxt_s;
  logic [GAP_W-1:0]     gap_cnt_r, gap_cnt_nxt_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (i_valid),
    .ptr   (ptr_r),
    .grant (arb_grant_s),
    .idx   (arb_idx_s),
    .found (arb_found_s)
  );

  // Next-state and next-register logic; o_ready is the only combinational output.
  always_comb begin
    state_nxt_s   = state_r;
    grant_nxt_s   = grant_r;
    gidx_nxt_s    = gidx_r;
    ptr_nxt_s     = ptr_r;
    tx_data_nxt_s = tx_data_r;
    last_nxt_s    = last_r;
    gap_cnt_nxt_s = gap_cnt_r;
    ready_s       = '0;
    case (state_r)
      ARB: begin
        if (arb_found_s) begin
          grant_nxt_s = arb_grant_s;
          gidx_nxt_s  = arb_idx_s;
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = ARB;
        end
      end
      LOAD: begin
        // Packet lock: only the owner is offered ready, and we wait for it indefinitely.
        ready_s[gidx_r] = i_valid[gidx_r];
        if (i_valid[gidx_r]) begin
          tx_data_nxt_s = i_data[gidx_r*DATA_BITS +: DATA_BITS];
          last_nxt_s    = i_last[gidx_r];
          state_nxt_s   = START;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      START: begin
        state_nxt_s = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_tx_busy) begin
          state_nxt_s = WAIT_DONE;
        end else begin
          state_nxt_s = WAIT_ACK;
        end
      end
      WAIT_DONE: begin
        if (!i_tx_busy && last_r) begin
          ptr_nxt_s     = gidx_r;
          grant_nxt_s   = '0;
          gap_cnt_nxt_s = '0;
          state_nxt_s   = (GAP_CYCLES > 0) ? GAP : ARB;
        end else if (!i_tx_busy) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = ARB;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
          state_nxt_s   = GAP;
        end
      end
      default: begin
        grant_nxt_s = '0;
        state_nxt_s = ARB;
      end
    endcase
  end

  // State and output registers; start and busy are registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r   <= ARB;
      grant_r   <= '0;
      gidx_r    <= '0;
      ptr_r     <= PTR_INIT;
      tx_data_r <= '0;
      last_r    <= 1'b0;
      gap_cnt_r <= '0;
      start_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      gidx_r    <= gidx_nxt_s;
      ptr_r     <= ptr_nxt_s;
      tx_data_r <= tx_data_nxt_s;
      last_r    <= last_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
      start_r   <= (state_nxt_s == START);
      busy_r    <= (state_nxt_s != ARB);
    end
  end

  assign o_ready    = ready_s;
  assign o_grant    = grant_r;
  assign o_tx_data  = tx_data_r;
  assign o_tx_start = start_r;
  assign o_busy     = busy_r;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte-stream requesters using round-robin arbitration with packet locking.
- Once granted, a requester keeps the transmitter until it hands over a byte flagged last. An optional idle gap follows, then arbitration reruns.
- Sits between the protocol sources (debug console, telemetry, log) and the single UART TX serializer. Drives the serializer's data/start inputs and watches its busy output.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- DATA_BITS, 8, width of one byte/word; must match the serializer
- GAP_CYCLES, 0, idle clock cycles inserted after a packet's last byte before rearbitration (0 = none)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_data  in  NUM_REQ*DATA_BITS  requester k's byte in bits [k*DATA_BITS +: DATA_BITS]
- i_valid  in  NUM_REQ  requester k has a byte on i_data
- i_last  in  NUM_REQ  byte from requester k ends its packet
- o_ready  out  NUM_REQ  byte from requester k accepted this cycle (i_valid[k] && o_ready[k])
- o_grant  out  NUM_REQ  one-hot current owner, all-zero when unowned
- o_tx_data  out  DATA_BITS  byte to serializer
- o_tx_start  out  1  one-cycle start pulse to serializer
- i_tx_busy  in  1  serializer busy
- o_busy  out  1  arbiter not in ARB state

Behaviour:
- Reset is asynchronous and active-high; one clock. Reset forces:
  - state = ARB
  - o_grant = 0, o_ready = 0, o_tx_start = 0, o_tx_data = 0
  - rr pointer = NUM_REQ-1, so requester 0 has first priority
  - gap counter = 0
- States (shared enum): ARB, LOAD, START, WAIT_ACK, WAIT_DONE, GAP.
- ARB: if any i_valid, grant the first valid index searching from pointer+1 with wrap-around modulo NUM_REQ; register o_grant; go to LOAD. With none valid, stay.
- LOAD: o_ready[g] = i_valid[g], combinational and only for the granted index. On handshake, capture the byte into o_tx_data and i_last into last_q, then go to START. Without valid, hold LOAD and the grant indefinitely (packet lock; there is no timeout).
- START: o_tx_start = 1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for i_tx_busy = 1, which the serializer raises one cycle after start, then go to WAIT_DONE.
  - The start pulse is never repeated.
  - The bench asserts that busy rises within 1 cycle.
- WAIT_DONE: on i_tx_busy = 0:
  - last_q = 0: go to LOAD.
  - last_q = 1: set pointer = g, clear o_grant, then go to GAP if GAP_CYCLES > 0, else ARB.
- GAP: count GAP_CYCLES cycles, then go to ARB. Requests arriving during the gap are not granted.
- Latency: valid seen in ARB at cycle t gives grant at t+1, ready at t+1 (if valid is held), start at t+2, busy at t+3.
- Back-to-back bytes within a packet: LOAD is re-entered the cycle after busy falls, so the minimum idle line time between bytes is 3 cycles.
- Widths: the pointer and the grant index are $clog2(NUM_REQ) bits. o_tx_data holds its value after start until the next LOAD capture.
- Simultaneous events:
  - Valid deasserting in the same cycle as ARB samples it: the grant still issues and LOAD waits.
  - A requester's valid is ignored while another requester owns the transmitter.
  - A single-requester case is served every packet.
- Reset mid-operation: returns to ARB immediately and the current byte is lost. The serializer must share the reset net so it is not left mid-frame with a stale start.
- Fairness: after a packet from k, priority order is k+1 ... k (k is last), giving a bounded wait of NUM_REQ-1 packets.

Decomposition:
- Package uart_pkg:
  - arb_state_t enum
  - function rr_next(ptr, req) returning the index and a found flag
- Sub-module rr_arbiter: the combinational round-robin priority search (req vector, pointer in; one-hot grant and index out), reusable by other shared-resource blocks.
- The top contains the FSM, the capture registers and the gap counter. The serializer itself is instantiated one level up, not inside this block.

Test Plan:
- Single request: req1 sends 0xA5 with last=1 -> grant=0010 one cycle later, o_ready[1] pulse, o_tx_start 2 cycles after ARB sample, o_tx_data=0xA5, grant clears when busy falls.
- Contention: req0, req2 and req3 all valid at once, 1-byte packets each -> service order 0,2,3; next round with req0 and req3 valid -> order 0,3.
- Packet lock: req1 sends 3 bytes (0x11, 0x22, 0x33 with last on 0x33) while req0 stays valid -> req0 is not granted until after 0x33 completes; grant stays 0010 throughout, even when req1 idles 20 cycles before 0x22.
- Gap: GAP_CYCLES=5, two requesters back-to-back -> exactly 5 cycles after busy falls before the next grant, o_busy high during the gap.
- Async reset: assert reset mid-WAIT_DONE between clock edges -> all outputs 0 immediately without a clock edge; after release, req0 (pointer=NUM_REQ-1) wins a tie with req1.
- Protocol check: single o_tx_start pulse per byte, o_ready one-hot, and o_ready[k] never asserted unless grant[k], all checked every cycle under a random-valid stress of 10k cycles.
